// File: rtl/sram_rd_streamer.sv
// Burst read sequencer for the single-port sram macro: issues one read per cycle
// and re-times the Q words through a 2-entry capture FIFO onto a valid/ready stream.
module sram_rd_streamer #(
   parameter int WIDTH     = 128,
   parameter int ADD_WIDTH = 11,
   parameter int LEN_WIDTH = 12
) (
   input  logic                 CLK,
   input  logic                 RSTN,
   input  logic                 start,
   input  logic [ADD_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0] len,
   output logic                 busy,
   output logic                 done,
   output logic                 CEN,
   output logic                 WEN,
   output logic [ADD_WIDTH-1:0] A,
   input  logic [WIDTH-1:0]     Q,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   // Stream handshake: a word transfers on every cycle where out_valid and
   // out_ready are both high; out_data is held until that transfer happens.

   state_t               state_q, state_d;
   logic [ADD_WIDTH-1:0] issue_addr_q, issue_addr_d;
   logic [ADD_WIDTH-1:0] last_a_q, last_a_d;
   logic [LEN_WIDTH-1:0] to_issue_q, to_issue_d;
   logic [LEN_WIDTH-1:0] to_deliver_q, to_deliver_d;
   logic                 inflight_q, inflight_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [WIDTH-1:0]     fifo_q [2];
   logic [WIDTH-1:0]     fifo_d [2];
   logic                 rd_ptr_q, rd_ptr_d;
   logic                 wr_ptr_q, wr_ptr_d;
   logic [1:0]           count_q, count_d;

   logic                 pop;
   logic                 issue;
   logic [2:0]           occ;

   assign out_valid = (count_q != 2'd0);
   assign out_data  = fifo_q[rd_ptr_q];
   assign pop       = out_valid & out_ready;

   // Slots already claimed once this cycle's pop is accounted for; a pop frees
   // a slot in time for the read issued in the same cycle.
   assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue = (state_q == ST_RUN) && (to_issue_q != '0) && (occ < 3'd2);

   assign CEN       = ~issue;
   assign WEN       = 1'b1;
   assign A         = issue ? issue_addr_q : last_a_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign dbg_state = state_q;

   always_comb begin
      state_d      = state_q;
      issue_addr_d = issue_addr_q;
      last_a_d     = last_a_q;
      to_issue_d   = to_issue_q;
      to_deliver_d = to_deliver_q;
      inflight_d   = issue;
      fifo_d       = fifo_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q + {1'b0, inflight_q} - {1'b0, pop};

      if (issue) begin
         issue_addr_d = issue_addr_q + 1'b1;
         last_a_d     = issue_addr_q;
         to_issue_d   = to_issue_q - 1'b1;
      end

      if (inflight_q) begin
         fifo_d[wr_ptr_q] = Q;
         wr_ptr_d         = ~wr_ptr_q;
      end

      if (pop) begin
         rd_ptr_d     = ~rd_ptr_q;
         to_deliver_d = to_deliver_q - 1'b1;
      end

      case (state_q)
         ST_IDLE, ST_FINISH: begin
            if (state_q == ST_FINISH) state_d = ST_IDLE;
            // A zero-length burst passes through RUN for one cycle so that done
            // lands one cycle after the start edge, with no read issued.
            if (start) begin
               issue_addr_d = base_addr;
               to_issue_d   = len;
               to_deliver_d = len;
               state_d      = ST_RUN;
            end
         end
         ST_RUN: begin
            if (to_deliver_q == '0) state_d = ST_FINISH;
            else if (pop && (to_deliver_q == LEN_WIDTH'(1))) state_d = ST_FINISH;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_FINISH);
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q      <= ST_IDLE;
         issue_addr_q <= '0;
         last_a_q     <= '0;
         to_issue_q   <= '0;
         to_deliver_q <= '0;
         inflight_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fifo_q[0]    <= '0;
         fifo_q[1]    <= '0;
         rd_ptr_q     <= 1'b0;
         wr_ptr_q     <= 1'b0;
         count_q      <= 2'd0;
      end else begin
         state_q      <= state_d;
         issue_addr_q <= issue_addr_d;
         last_a_q     <= last_a_d;
         to_issue_q   <= to_issue_d;
         to_deliver_q <= to_deliver_d;
         inflight_q   <= inflight_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         fifo_q[0]    <= fifo_d[0];
         fifo_q[1]    <= fifo_d[1];
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
      end
   end

endmodule

// File: tb/tb_sram_rd_streamer.sv
// Bench for sram_rd_streamer: behavioural SRAM, expected-word queue built from
// memory contents, and a negedge monitor for address order, data order and stream rules.
module tb_sram_rd_streamer;

   localparam int WIDTH     = 128;
   localparam int ADD_WIDTH = 11;
   localparam int LEN_WIDTH = 12;
   localparam int DEPTH     = 2048;

   logic                 CLK;
   logic                 RSTN;
   logic                 start;
   logic [ADD_WIDTH-1:0] base_addr;
   logic [LEN_WIDTH-1:0] len;
   logic                 busy;
   logic                 done;
   logic                 CEN;
   logic                 WEN;
   logic [ADD_WIDTH-1:0] A;
   logic [WIDTH-1:0]     Q;
   logic [WIDTH-1:0]     out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [1:0]           dbg_state;

   sram_rd_streamer #(.WIDTH(WIDTH), .ADD_WIDTH(ADD_WIDTH), .LEN_WIDTH(LEN_WIDTH)) dut (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .CEN       (CEN),
      .WEN       (WEN),
      .A         (A),
      .Q         (Q),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- behavioural SRAM ----------------
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] q_r;
   assign Q = q_r;
   always @(posedge CLK) if (!CEN && WEN) q_r <= mem[A];

   // ---------------- scoreboard ----------------
   logic [WIDTH-1:0]     exp_q[$];
   logic [ADD_WIDTH-1:0] exp_addr;
   int                   issued;
   int                   popped;
   int                   cen_cnt;
   bit                   hold_pending;
   logic [WIDTH-1:0]     held_data;
   int                   test_cnt;
   int                   fail_cnt;
   bit                   ready_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      test_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (RSTN) begin
         logic [WIDTH-1:0] exp_w;
         if (!CEN) begin
            chk("addr", WIDTH'(A), WIDTH'(exp_addr));
            chk("wen", WIDTH'(WEN), WIDTH'(1));
            exp_addr = exp_addr + 1'b1;
            issued++;
            cen_cnt++;
         end
         if (hold_pending) begin
            chk("hold_valid", WIDTH'(out_valid), WIDTH'(1));
            chk("hold_data", out_data, held_data);
         end
         if (out_valid && out_ready) begin
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            chk("pop_data", out_data, exp_w);
            popped++;
         end
         chk("ahead", WIDTH'(issued - popped <= 2), WIDTH'(1));
         hold_pending = out_valid && !out_ready;
         held_data    = out_data;
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic ready_for(input int mode, input int k);
      if (mode == 0) return 1'b1;
      if (mode == 1) return ready_pat[k % 6];
      return 1'($urandom_range(0, 1));
   endfunction

   // mode 0: ready always high, 1: fixed toggle pattern, 2: random ready.
   // glitch_cyc >= 0 raises start again in that cycle of the burst.
   task automatic run_burst(input int base, input int n, input int mode, input int glitch_cyc);
      int cyc, done_cyc, first_valid, gaps, limit;
      for (int i = 0; i < n; i++) exp_q.push_back(mem[(base + i) % DEPTH]);
      exp_addr  = ADD_WIDTH'(base);
      issued    = 0;
      popped    = 0;
      cen_cnt   = 0;
      start     = 1'b1;
      base_addr = ADD_WIDTH'(base);
      len       = LEN_WIDTH'(n);
      out_ready = ready_for(mode, 0);
      @(posedge CLK); #1;
      start       = 1'b0;
      cyc         = 0;
      done_cyc    = -1;
      first_valid = -1;
      gaps        = 0;
      limit       = 8 * n + 40;
      while (done_cyc < 0 && cyc < limit) begin
         @(negedge CLK);
         chk("busy_run", WIDTH'(busy), WIDTH'(1));
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (cyc >= 2 && cyc <= n + 1 && !out_valid) gaps++;
         if (done) done_cyc = cyc;
         @(posedge CLK); #1;
         cyc++;
         out_ready = ready_for(mode, cyc);
         start     = (cyc == glitch_cyc);
         if (start) begin
            base_addr = ADD_WIDTH'($urandom_range(0, DEPTH - 1));
            len       = LEN_WIDTH'(7);
         end
      end
      start = 1'b0;
      chk("done_seen", WIDTH'(done_cyc >= 0), WIDTH'(1));
      @(negedge CLK);
      chk("done_pulse", WIDTH'(done), WIDTH'(0));
      chk("busy_after", WIDTH'(busy), WIDTH'(0));
      chk("all_words", WIDTH'(exp_q.size()), WIDTH'(0));
      chk("cen_count", WIDTH'(cen_cnt), WIDTH'(n));
      chk("valid_after", WIDTH'(out_valid), WIDTH'(0));
      if (mode == 0) begin
         chk("done_time", WIDTH'(done_cyc), (n == 0) ? WIDTH'(1) : WIDTH'(n + 2));
         if (n > 0) begin
            chk("first_word", WIDTH'(first_valid), WIDTH'(2));
            chk("no_gaps", WIDTH'(gaps), WIDTH'(0));
         end
      end
      exp_q.delete();
      hold_pending = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, WIDTH'(busy), WIDTH'(0));
      chk({tag, "_done"}, WIDTH'(done), WIDTH'(0));
      chk({tag, "_cen"}, WIDTH'(CEN), WIDTH'(1));
      chk({tag, "_wen"}, WIDTH'(WEN), WIDTH'(1));
      chk({tag, "_a"}, WIDTH'(A), WIDTH'(0));
      chk({tag, "_valid"}, WIDTH'(out_valid), WIDTH'(0));
      chk({tag, "_data"}, out_data, WIDTH'(0));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int rb, rl;
      test_cnt     = 0;
      fail_cnt     = 0;
      hold_pending = 1'b0;
      issued       = 0;
      popped       = 0;
      cen_cnt      = 0;
      exp_addr     = '0;
      RSTN         = 1'b0;
      start        = 1'b0;
      base_addr    = '0;
      len          = '0;
      out_ready    = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         mem[i] = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 4; i++) mem[10 + i] = WIDTH'(8'hA0 + i);

      #3;
      check_reset_outputs("reset");
      @(posedge CLK); #1;
      RSTN = 1'b1;
      @(posedge CLK); #1;

      run_burst(10, 4, 0, -1);          // basic
      run_burst(2046, 4, 0, -1);        // address wrap
      run_burst(700, 6, 1, -1);         // toggling backpressure
      run_burst(55, 0, 0, -1);          // zero length
      run_burst(500, 5, 0, 3);          // start while busy
      for (int t = 0; t < 4; t++) begin
         rb = $urandom_range(0, DEPTH - 1);
         rl = $urandom_range(1, 24);
         run_burst(rb, rl, 2, -1);
      end

      // reset in the middle of an 8-word burst
      for (int i = 0; i < 8; i++) exp_q.push_back(mem[300 + i]);
      exp_addr  = ADD_WIDTH'(300);
      issued    = 0;
      popped    = 0;
      start     = 1'b1;
      base_addr = ADD_WIDTH'(300);
      len       = LEN_WIDTH'(8);
      out_ready = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK); #2;
         if (popped >= 3) break;
      end
      chk("rst_reached", WIDTH'(popped >= 3), WIDTH'(1));
      RSTN = 1'b0;
      #1;
      check_reset_outputs("midrst");
      exp_q.delete();
      hold_pending = 1'b0;
      @(posedge CLK); #1;
      check_reset_outputs("midrst_held");
      RSTN = 1'b1;
      @(posedge CLK); #1;
      run_burst(100, 2, 0, -1);

      run_burst(0, 2048, 0, -1);        // full-memory burst

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
